axi_burst_slave_mem: RTL

Parametrised AXI4 slave with an internal word-addressed memory. Supports FIXED, INCR and WRAP bursts, byte strobes and configurable data width, depth and burst length. Write and read channels run concurrently and independently. Serves as the bench-side and SoC-side target behind the existing AXI interface bundle, replacing the fixed 32-bit single-mode slave.

---
 rtl/axi_burst_slave_mem_if.sv | 50 +++++
 rtl/axi_burst_slave_mem.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/axi_burst_slave_mem_if.sv
// AXI4 write/read channel bundle shared by the burst slave memory and its masters.
// Clock and reset travel as plain ports alongside this interface.
interface axi_burst_slave_mem_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 8
);
    logic                  awvalid;
    logic                  awready;
    logic [ADDR_W-1:0]     awadd;
    logic [LEN_W-1:0]      awlen;
    logic [2:0]            awsize;
    logic [1:0]            awburst;
    logic                  wvalid;
    logic                  wready;
    logic [DATA_W-1:0]     wdata;
    logic [DATA_W/8-1:0]   wstrb;
    logic                  wlast;
    logic                  bvalid;
    logic                  bready;
    logic [1:0]            bresp;
    logic                  arvalid;
    logic                  arready;
    logic [ADDR_W-1:0]     aradd;
    logic [LEN_W-1:0]      arlen;
    logic [2:0]            arsize;
    logic [1:0]            arburst;
    logic                  rvalid;
    logic                  rready;
    logic [DATA_W-1:0]     rdata;
    logic [1:0]            rresp;
    logic                  rlast;
    logic [LEN_W-1:0]      rcount;

    modport slave (
        input  awvalid, awadd, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast, bready,
        input  arvalid, aradd, arlen, arsize, arburst, rready,
        output awready, wready, bvalid, bresp,
        output arready, rvalid, rdata, rresp, rlast, rcount
    );

    modport master (
        output awvalid, awadd, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast, bready,
        output arvalid, aradd, arlen, arsize, arburst, rready,
        input  awready, wready, bvalid, bresp,
        input  arready, rvalid, rdata, rresp, rlast, rcount
    );
endinterface

// File: rtl/axi_burst_slave_mem.sv
// AXI4 slave over a word-addressed memory: FIXED/INCR/WRAP bursts, byte strobes,
// independent write and read engines sharing one array (read-before-write).
module axi_burst_slave_mem #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_DEPTH = 256,
    parameter int LEN_W     = 8
) (
    input  logic                 aclk,
    input  logic                 reset,
    axi_burst_slave_mem_if.slave bus
);
    localparam int STRB_W = DATA_W / 8;
    localparam int OFF_W  = $clog2(STRB_W);
    localparam int IDX_W  = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [LEN_W-1:0]  len_t;

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    function automatic addr_t step_of(input logic [2:0] size);
        return addr_t'(1) << size;
    endfunction

    function automatic addr_t next_addr(input addr_t addr, input len_t len,
                                        input logic [2:0] size, input logic [1:0] burst);
        addr_t span;
        addr_t nxt;
        span = (addr_t'(len) + addr_t'(1)) << size;
        case (burst)
            2'b01:   nxt = addr + step_of(size);
            2'b10:   nxt = (addr & ~(span - addr_t'(1))) + ((addr + step_of(size)) & (span - addr_t'(1)));
            default: nxt = addr;
        endcase
        return nxt;
    endfunction

    // Burst-wide errors: decided once from the start address and held for every beat.
    function automatic logic param_err(input addr_t addr, input len_t len,
                                       input logic [2:0] size, input logic [1:0] burst);
        logic wrap_len_ok;
        logic misaligned;
        wrap_len_ok = (len == len_t'(1)) || (len == len_t'(3)) ||
                      (len == len_t'(7)) || (len == len_t'(15));
        misaligned  = (addr & (step_of(size) - addr_t'(1))) != '0;
        return (size > 3'(OFF_W)) || (burst == 2'b11) ||
               ((burst == 2'b10) && (!wrap_len_ok || misaligned));
    endfunction

    function automatic logic oob(input addr_t addr);
        return (addr >> OFF_W) >= addr_t'(MEM_DEPTH);
    endfunction

    function automatic logic [IDX_W-1:0] index_of(input addr_t addr);
        addr_t w;
        w = addr >> OFF_W;
        return w[IDX_W-1:0];
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic       {R_IDLE, R_DATA}         rstate_t;

    wstate_t     wstate;
    addr_t       waddr;
    len_t        wlen;
    len_t        wbeat;
    logic [2:0]  wsize;
    logic [1:0]  wburst;
    logic        wperr;
    logic        werr;
    logic        wfire;
    logic        wfinal;
    logic        wbeat_err;

    always_comb begin
        wfire     = (wstate == W_DATA) && bus.wvalid && bus.wready;
        wfinal    = (wbeat == wlen);
        wbeat_err = wperr || oob(waddr) || (bus.wlast != wfinal);
    end

    always_ff @(posedge aclk) begin
        if (wfire && !wbeat_err) begin
            for (int b = 0; b < STRB_W; b++) begin
                if (bus.wstrb[b]) begin
                    mem[index_of(waddr)][b*8 +: 8] <= bus.wdata[b*8 +: 8];
                end
            end
        end
    end

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            wstate      <= W_IDLE;
            bus.awready <= 1'b1;
            bus.wready  <= 1'b0;
            bus.bvalid  <= 1'b0;
            bus.bresp   <= 2'b00;
            waddr       <= '0;
            wlen        <= '0;
            wbeat       <= '0;
            wsize       <= '0;
            wburst      <= '0;
            wperr       <= 1'b0;
            werr        <= 1'b0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (bus.awvalid && bus.awready) begin
                        waddr       <= bus.awadd;
                        wlen        <= bus.awlen;
                        wsize       <= bus.awsize;
                        wburst      <= bus.awburst;
                        wperr       <= param_err(bus.awadd, bus.awlen, bus.awsize, bus.awburst);
                        werr        <= 1'b0;
                        wbeat       <= '0;
                        bus.awready <= 1'b0;
                        bus.wready  <= 1'b1;
                        wstate      <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (wfire) begin
                        waddr <= next_addr(waddr, wlen, wsize, wburst);
                        wbeat <= wbeat + len_t'(1);
                        werr  <= werr | wbeat_err;
                        if (wfinal) begin
                            bus.wready <= 1'b0;
                            bus.bvalid <= 1'b1;
                            bus.bresp  <= (werr || wbeat_err) ? 2'b10 : 2'b00;
                            wstate     <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (bus.bready) begin
                        bus.bvalid  <= 1'b0;
                        bus.awready <= 1'b1;
                        wstate      <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    rstate_t     rstate;
    addr_t       raddr;
    len_t        rlen;
    logic [2:0]  rsize;
    logic [1:0]  rburst;
    logic        rperr;
    addr_t       src_addr;
    len_t        src_len;
    len_t        src_count;
    logic [2:0]  src_size;
    logic [1:0]  src_burst;
    logic        src_err;
    logic        rload;

    // The beat about to be presented comes from AR on a new burst, else from the latched walker.
    always_comb begin
        if (rstate == R_IDLE) begin
            src_addr  = bus.aradd;
            src_len   = bus.arlen;
            src_size  = bus.arsize;
            src_burst = bus.arburst;
            src_count = bus.arlen;
            src_err   = param_err(bus.aradd, bus.arlen, bus.arsize, bus.arburst) || oob(bus.aradd);
            rload     = bus.arvalid && bus.arready;
        end else begin
            src_addr  = raddr;
            src_len   = rlen;
            src_size  = rsize;
            src_burst = rburst;
            src_count = bus.rcount - len_t'(1);
            src_err   = rperr || oob(raddr);
            rload     = bus.rvalid && bus.rready && !bus.rlast;
        end
    end

    always_ff @(posedge aclk or negedge reset) begin
        if (!reset) begin
            rstate      <= R_IDLE;
            bus.arready <= 1'b1;
            bus.rvalid  <= 1'b0;
            bus.rlast   <= 1'b0;
            bus.rdata   <= '0;
            bus.rresp   <= 2'b00;
            bus.rcount  <= '0;
            raddr       <= '0;
            rlen        <= '0;
            rsize       <= '0;
            rburst      <= '0;
            rperr       <= 1'b0;
        end else begin
            if (rload) begin
                bus.rdata  <= src_err ? '0 : mem[index_of(src_addr)];
                bus.rresp  <= src_err ? 2'b10 : 2'b00;
                bus.rcount <= src_count;
                bus.rlast  <= (src_count == '0);
                bus.rvalid <= 1'b1;
                raddr      <= next_addr(src_addr, src_len, src_size, src_burst);
            end
            case (rstate)
                R_IDLE: begin
                    if (rload) begin
                        rlen        <= bus.arlen;
                        rsize       <= bus.arsize;
                        rburst      <= bus.arburst;
                        rperr       <= param_err(bus.aradd, bus.arlen, bus.arsize, bus.arburst);
                        bus.arready <= 1'b0;
                        rstate      <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (bus.rvalid && bus.rready && bus.rlast) begin
                        bus.rvalid  <= 1'b0;
                        bus.rlast   <= 1'b0;
                        bus.arready <= 1'b1;
                        rstate      <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end
endmodule
